// File: rtl/sc_scratchpad_if.sv
// Bus between the systolic array / host and the scratchpad responder.
// Lane i occupies element [i] of every per-lane vector; lane 0 is the least significant element.
interface sc_scratchpad_if #(
  parameter int N = 4
);
  // Handshake: sc_valid_queue[i] qualifies both addresses of lane i for one cycle and there is
  // no backpressure. sc_rvalid[i] and the read data answer it exactly one cycle later.
  // Reads and host writes are honoured only while ready is high.
  logic [N-1:0][31:0] sc_x_queue;
  logic [N-1:0][31:0] sc_w_queue;
  logic [N-1:0]       sc_valid_queue;
  logic [N-1:0][31:0] sc_x_data;
  logic [N-1:0][31:0] sc_w_data;
  logic [N-1:0]       sc_rvalid;
  logic               wr_en;
  logic [31:0]        wr_addr;
  logic [31:0]        wr_data;
  logic               ready;
  logic               oob_err;

  modport master (
    output sc_x_queue, sc_w_queue, sc_valid_queue, wr_en, wr_addr, wr_data,
    input  sc_x_data, sc_w_data, sc_rvalid, ready, oob_err
  );

  modport slave (
    input  sc_x_queue, sc_w_queue, sc_valid_queue, wr_en, wr_addr, wr_data,
    output sc_x_data, sc_w_data, sc_rvalid, ready, oob_err
  );
endinterface

// File: rtl/sc_scratchpad_responder.sv
// Multi-port scratchpad serving per-lane X/W operand fetches with one-cycle latency.
// After reset a clear sweep zeroes CLR_LANES words per cycle before ready is raised.
module sc_scratchpad_responder #(
  parameter int N         = 4,
  parameter int DEPTH     = 8192,
  parameter int CLR_LANES = 16
) (
  input  logic            clk,
  input  logic            rst,
  sc_scratchpad_if.slave  bus,
  output logic            dbg_state
);
  localparam int AW  = $clog2(DEPTH);
  localparam int CLW = $clog2(CLR_LANES);
  localparam int GW  = AW - CLW;

  typedef logic [31:0] word_t;
  typedef enum logic {ST_CLEAR = 1'b0, ST_READY = 1'b1} state_t;

  state_t        state;
  logic [GW-1:0] clr_grp;
  word_t         mem [DEPTH];
  logic [N-1:0]  x_oob;
  logic [N-1:0]  w_oob;
  logic          wr_oob;
  logic          any_oob;

  assign dbg_state = state;

  // Any set bit above the index range is out of range; addresses are never wrapped.
  always_comb begin
    x_oob = '0;
    w_oob = '0;
    for (int i = 0; i < N; i++) begin
      x_oob[i] = (bus.sc_x_queue[i][31:AW] != '0);
      w_oob[i] = (bus.sc_w_queue[i][31:AW] != '0);
    end
    wr_oob  = (bus.wr_addr[31:AW] != '0);
    any_oob = (bus.wr_en && wr_oob) || (|(bus.sc_valid_queue & (x_oob | w_oob)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_CLEAR;
      clr_grp     <= '0;
      bus.ready   <= 1'b0;
      bus.oob_err <= 1'b0;
    end else if (state == ST_CLEAR) begin
      clr_grp <= clr_grp + GW'(1);
      if (clr_grp == '1) begin
        state     <= ST_READY;
        bus.ready <= 1'b1;
      end
    end else if (any_oob) begin
      bus.oob_err <= 1'b1;
    end
  end

  // Storage has no reset; the clear sweep rezeroes it after every reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_CLEAR) begin
        for (int j = 0; j < CLR_LANES; j++) begin
          mem[{clr_grp, CLW'(j)}] <= '0;
        end
      end else if (bus.wr_en && !wr_oob) begin
        mem[bus.wr_addr[AW-1:0]] <= bus.wr_data;
      end
    end
  end

  // Non-blocking reads of mem give read-before-write against a same-cycle host write.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sc_x_data <= '0;
      bus.sc_w_data <= '0;
      bus.sc_rvalid <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (state == ST_READY && bus.sc_valid_queue[i]) begin
          bus.sc_rvalid[i] <= 1'b1;
          bus.sc_x_data[i] <= x_oob[i] ? '0 : mem[bus.sc_x_queue[i][AW-1:0]];
          bus.sc_w_data[i] <= w_oob[i] ? '0 : mem[bus.sc_w_queue[i][AW-1:0]];
        end else begin
          bus.sc_rvalid[i] <= 1'b0;
          bus.sc_x_data[i] <= '0;
          bus.sc_w_data[i] <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sc_scratchpad_responder.sv
// Directed bench for sc_scratchpad_responder: clear timing, tile load/read, partial lanes,
// read-before-write, out-of-range handling and reset during clear and during operation.
module tb_sc_scratchpad_responder;
  localparam int N = 4;
  localparam int CLEAR_CYCLES = 8192 / 16;

  typedef struct {
    logic               wr_en;
    logic [31:0]        wr_addr;
    logic [31:0]        wr_data;
    logic [3:0]         valid;
    logic [3:0][31:0]   xa;
    logic [3:0][31:0]   wa;
    logic [3:0]         exp_rvalid;
    logic [3:0][31:0]   exp_x;
    logic [3:0][31:0]   exp_w;
    logic               exp_oob;
  } vec_t;

  logic clk;
  logic rst;
  logic dbg_state;
  int   n_vec;
  int   n_miss;
  vec_t vecs_a[$];
  vec_t vecs_b[$];

  sc_scratchpad_if #(.N(N)) bus ();

  sc_scratchpad_responder #(.N(N), .DEPTH(8192), .CLR_LANES(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0][31:0] q4(input logic [31:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic vec_t mk(input logic we, input logic [31:0] wa_, input logic [31:0] wd,
                              input logic [3:0] v, input logic [3:0][31:0] xa, input logic [3:0][31:0] wa,
                              input logic [3:0] erv, input logic [3:0][31:0] ex,
                              input logic [3:0][31:0] ew, input logic eoob);
    vec_t t;
    t.wr_en = we; t.wr_addr = wa_; t.wr_data = wd; t.valid = v; t.xa = xa; t.wa = wa;
    t.exp_rvalid = erv; t.exp_x = ex; t.exp_w = ew; t.exp_oob = eoob;
    return t;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.sc_valid_queue = '0; bus.sc_x_queue = '0; bus.sc_w_queue = '0;
  endtask

  task automatic apply_vec(input vec_t v, input string tag, input int idx);
    @(negedge clk);
    bus.wr_en = v.wr_en; bus.wr_addr = v.wr_addr; bus.wr_data = v.wr_data;
    bus.sc_valid_queue = v.valid; bus.sc_x_queue = v.xa; bus.sc_w_queue = v.wa;
    @(posedge clk);
    #1;
    check($sformatf("%s[%0d].rvalid", tag, idx), 128'(bus.sc_rvalid), 128'(v.exp_rvalid));
    check($sformatf("%s[%0d].x_data", tag, idx), 128'(bus.sc_x_data), 128'(v.exp_x));
    check($sformatf("%s[%0d].w_data", tag, idx), 128'(bus.sc_w_data), 128'(v.exp_w));
    check($sformatf("%s[%0d].oob_err", tag, idx), 128'(bus.oob_err), 128'(v.exp_oob));
  endtask

  // Counts posedges from the rst deassert until ready is seen high. With probe set, a write to
  // 0x10 and a full read are offered in the first clear cycle and must be ignored.
  task automatic wait_ready(input string tag, input bit probe);
    int cyc;
    cyc = 0;
    if (probe) begin
      bus.wr_en = 1'b1; bus.wr_addr = 32'h10; bus.wr_data = 32'hDEAD_BEEF;
      bus.sc_valid_queue = 4'b1111; bus.sc_x_queue = q4(0, 1, 2, 32'h10);
    end
    while (cyc < 2000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (probe && cyc == 1) begin
        check({tag, ".clear_rvalid"}, 128'(bus.sc_rvalid), 128'(0));
        check({tag, ".clear_x_data"}, 128'(bus.sc_x_data), 128'(0));
        check({tag, ".clear_oob"}, 128'(bus.oob_err), 128'(0));
        drive_idle();
      end
      if (bus.ready) break;
    end
    check({tag, ".ready_latency"}, 128'(cyc), 128'(CLEAR_CYCLES));
    check({tag, ".ready_state"}, 128'(dbg_state), 128'(1));
  endtask

  initial begin
    logic [3:0][31:0] z;
    z = '0;
    n_vec = 0;
    n_miss = 0;

    // Vector tables, phase A: after the first clear
    vecs_a.push_back(mk(0, 0, 0, 4'b0011, q4(0, 32'h10, 0, 0), q4(32'h1FFF, 32'h1FFF, 0, 0),
                        4'b0011, z, z, 0));
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        vecs_a.push_back(mk(1, 32'(r * 4 + c), 32'h3F80_0000 + 32'(r * 4 + c), 0, z, z, 0, z, z, 0));
        vecs_a.push_back(mk(1, 32'h1000 + 32'(r * 4 + c), 32'h3F80_0000 + 32'(r * 4 + c), 0, z, z, 0, z, z, 0));
      end
    end
    vecs_a.push_back(mk(1, 32'h20, 32'hAAAA_5555, 0, z, z, 0, z, z, 0));
    vecs_a.push_back(mk(0, 0, 0, 4'b1111, q4(0, 1, 2, 3), q4(32'h1000, 32'h1001, 32'h1002, 32'h1003),
                        4'b1111, q4(32'h3F80_0000, 32'h3F80_0001, 32'h3F80_0002, 32'h3F80_0003),
                        q4(32'h3F80_0000, 32'h3F80_0001, 32'h3F80_0002, 32'h3F80_0003), 0));
    // Invalid lanes carry out-of-range addresses: no data, no rvalid, no error
    vecs_a.push_back(mk(0, 0, 0, 4'b0101, q4(4, 32'h3000, 6, 32'h3000), q4(32'h1004, 32'h3000, 32'h1006, 32'h3000),
                        4'b0101, q4(32'h3F80_0004, 0, 32'h3F80_0006, 0),
                        q4(32'h3F80_0004, 0, 32'h3F80_0006, 0), 0));
    vecs_a.push_back(mk(0, 0, 0, 4'b1111, q4(12, 13, 14, 15), q4(32'h100C, 32'h100D, 32'h100E, 32'h100F),
                        4'b1111, q4(32'h3F80_000C, 32'h3F80_000D, 32'h3F80_000E, 32'h3F80_000F),
                        q4(32'h3F80_000C, 32'h3F80_000D, 32'h3F80_000E, 32'h3F80_000F), 0));
    vecs_a.push_back(mk(1, 32'h20, 32'h1234_5678, 4'b0001, q4(32'h20, 0, 0, 0), q4(32'h20, 0, 0, 0),
                        4'b0001, q4(32'hAAAA_5555, 0, 0, 0), q4(32'hAAAA_5555, 0, 0, 0), 0));
    vecs_a.push_back(mk(0, 0, 0, 4'b0001, q4(32'h20, 0, 0, 0), q4(0, 0, 0, 0),
                        4'b0001, q4(32'h1234_5678, 0, 0, 0), q4(32'h3F80_0000, 0, 0, 0), 0));
    vecs_a.push_back(mk(0, 0, 0, 4'b1111, q4(5, 5, 5, 5), q4(32'h1005, 32'h1005, 32'h1005, 32'h1005),
                        4'b1111, q4(32'h3F80_0005, 32'h3F80_0005, 32'h3F80_0005, 32'h3F80_0005),
                        q4(32'h3F80_0005, 32'h3F80_0005, 32'h3F80_0005, 32'h3F80_0005), 0));
    vecs_a.push_back(mk(0, 0, 0, 4'b0100, q4(0, 0, 32'h2000, 0), q4(0, 0, 32'h1000, 0),
                        4'b0100, z, q4(0, 0, 32'h3F80_0000, 0), 1));
    vecs_a.push_back(mk(0, 0, 0, 4'b0001, q4(0, 0, 0, 0), q4(32'h1001, 0, 0, 0),
                        4'b0001, q4(32'h3F80_0000, 0, 0, 0), q4(32'h3F80_0001, 0, 0, 0), 1));
    vecs_a.push_back(mk(1, 32'hFFFF_0000, 32'hBAD0_BAD0, 0, z, z, 0, z, z, 1));
    vecs_a.push_back(mk(1, 32'h2020, 32'hBAD1_BAD1, 0, z, z, 0, z, z, 1));
    vecs_a.push_back(mk(0, 0, 0, 4'b0011, q4(0, 32'h20, 0, 0), q4(32'h1000, 0, 0, 0),
                        4'b0011, q4(32'h3F80_0000, 32'h1234_5678, 0, 0),
                        q4(32'h3F80_0000, 32'h3F80_0000, 0, 0), 1));

    // Phase B: after reset in READY and reset mid-clear, memory must read as zero again
    vecs_b.push_back(mk(0, 0, 0, 4'b1111, q4(32'h20, 32'h10, 0, 5), q4(32'h1000, 32'h1003, 32'h1FFF, 0),
                        4'b1111, z, z, 0));

    // Reset state
    drive_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.ready", 128'(bus.ready), 128'(0));
    check("reset.oob_err", 128'(bus.oob_err), 128'(0));
    check("reset.rvalid", 128'(bus.sc_rvalid), 128'(0));
    check("reset.x_data", 128'(bus.sc_x_data), 128'(0));
    check("reset.w_data", 128'(bus.sc_w_data), 128'(0));
    check("reset.state", 128'(dbg_state), 128'(0));

    @(negedge clk);
    rst = 1'b0;
    wait_ready("clear1", 1'b1);

    for (int k = 0; k < vecs_a.size(); k++) apply_vec(vecs_a[k], "A", k);

    // Reset while READY with live requests: outputs zero, error cleared
    @(negedge clk);
    bus.sc_valid_queue = 4'b1111;
    bus.sc_x_queue = q4(0, 1, 2, 3);
    bus.sc_w_queue = q4(32'h1000, 32'h1001, 32'h1002, 32'h1003);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_ready.rvalid", 128'(bus.sc_rvalid), 128'(0));
    check("rst_ready.x_data", 128'(bus.sc_x_data), 128'(0));
    check("rst_ready.w_data", 128'(bus.sc_w_data), 128'(0));
    check("rst_ready.ready", 128'(bus.ready), 128'(0));
    check("rst_ready.oob_err", 128'(bus.oob_err), 128'(0));

    // Reset again at clear cycle 200
    @(negedge clk);
    rst = 1'b0;
    drive_idle();
    repeat (200) @(posedge clk);
    #1;
    check("mid_clear.ready", 128'(bus.ready), 128'(0));
    check("mid_clear.state", 128'(dbg_state), 128'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ready("clear2", 1'b0);

    for (int k = 0; k < vecs_b.size(); k++) apply_vec(vecs_b[k], "B", k);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sc_scratchpad_responder.md
Name: sc_scratchpad_responder

Overview:
- Synthesizable scratchpad responding to the systolic array's per-lane operand fetch requests (sc_x_queue/sc_w_queue/sc_valid_queue).
- Returns sc_x_data/sc_w_data one cycle later; replaces the behavioural scratchpad model in benches.
- Host-side write port fills X (im2col) and W (weight) tiles.
- A self-clear FSM zeroes the memory after reset so unwritten words read as 0.

Parameters:
- N, 4, number of array lanes (matches systolic_array_top N).
- DEPTH, 8192, number of 32-bit words; power of two.
- CLR_LANES, 16, words zeroed per cycle during clear; power of two, divides DEPTH.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- sc_x_queue  in  N x 32  per-lane X word address.
- sc_w_queue  in  N x 32  per-lane W word address.
- sc_valid_queue  in  N  per-lane request valid; one bit qualifies both the X and W address of that lane.
- sc_x_data  out  N x word_t  X read data, registered.
- sc_w_data  out  N x word_t  W read data, registered.
- sc_rvalid  out  N  per-lane response valid, registered.
- wr_en  in  1  host write strobe.
- wr_addr  in  32  host word address.
- wr_data  in  word_t  host write data.
- ready  out  1  high once clear completes; writes and reads are serviced only while high.
- oob_err  out  1  sticky flag for any out-of-range access.

Behaviour:
- Reset (rst=1 at posedge):
  - sc_x_data=0, sc_w_data=0, sc_rvalid=0, ready=0, oob_err=0.
  - FSM enters CLEAR; clr_idx=0.
  - Reset asserted mid-CLEAR or mid-READY restarts the clear from 0.
- FSM CLEAR:
  - Each cycle writes 0 to words clr_idx..clr_idx+CLR_LANES-1, then clr_idx += CLR_LANES.
  - On the cycle the last group is written, go to READY; ready=1 from the next cycle.
  - CLEAR lasts exactly DEPTH/CLR_LANES cycles after the rst-deassert edge.
  - In CLEAR, wr_en is dropped (no effect, no error).
  - In CLEAR, read requests return data=0 and sc_rvalid=0.
- FSM READY: remains in READY until rst.
- Read path (READY), latency 1:
  - For each lane i with sc_valid_queue[i]=1 at posedge k, at posedge k+1: sc_x_data[i]=mem[sc_x_queue[i]], sc_w_data[i]=mem[sc_w_queue[i]], sc_rvalid[i]=1.
  - Lanes with valid=0 drive data=0, rvalid=0 (never hold stale data).
  - All 2N read ports are independent; identical addresses on multiple lanes are legal and return the same word.
- Write path (READY): wr_en=1 writes mem[wr_addr]=wr_data at posedge.
- Simultaneous read and write of the same address in one cycle: the read returns the OLD value (read-before-write); new data is visible from the next request cycle.
- Out of range (address >= DEPTH):
  - A valid read lane returns 0 with sc_rvalid=1.
  - A write is dropped.
  - Either case sets oob_err=1, held until rst.
  - Addresses are never wrapped or truncated silently.
- Data is passed bit-exact; no arithmetic on word_t.

Test Plan:
- Clear timing: N=4, DEPTH=8192, CLR_LANES=16; deassert rst -> ready rises exactly 512 cycles later; afterwards a read of 0x0 and 0x1FFF returns 0x00000000, rvalid=1.
- Tile load/read: write X 4x4 tile at 0x0000+r*4+c and W tile at 0x1000+r*4+c with value 0x3F800000+r*4+c; issue valid=4'b1111, x addr {0,1,2,3}, w addr {0x1000..0x1003} -> next cycle x data {0x3F800000..0x3F800003}, w data {0x3F800000..0x3F800003}, rvalid=4'b1111.
- Partial lanes and stale data: valid=4'b0101 after a full read -> lanes 1 and 3 data=0, rvalid=0; lanes 0 and 2 return correct words.
- Read-before-write: mem[0x20]=0xAAAA5555; in the same cycle, wr_en to 0x20 with 0x12345678 and a lane-0 read of 0x20 -> returns 0xAAAA5555; a read next cycle -> 0x12345678.
- OOB: read lane 2 at 0x2000 -> data=0, rvalid[2]=1, oob_err=1 and stays 1; write to 0xFFFF_0000 -> memory unchanged; rst clears oob_err.
- Reset mid-clear/mid-operation: assert rst at clear cycle 200 -> ready stays 0 and rises 512 cycles after the new deassert; write in CLEAR at 0x10 -> reads 0 after ready; rst during READY with valid requests -> outputs 0 the next cycle, memory rezeroed.
